// File: rtl/iterative_multiplier_pkg.sv
// Shared definitions for the iterative multiplier: FSM encoding, digit width
// and the 4x4 base multiplier cell.
package iterative_multiplier_pkg;

  localparam int MUL_DIGIT = 4;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // 4x4 -> 8 unsigned base multiplier cell
  function automatic logic [7:0] base_mul4x4(input logic [3:0] x, input logic [3:0] y);
    base_mul4x4 = {4'd0, x} * {4'd0, y};
  endfunction

endpackage

// File: rtl/iterative_multiplier_row.sv
// Combinational row: multiplicand times one 4-bit digit, assembled from
// WIDTH/4 base multiplier cells whose partials are shifted and summed.
module iterative_multiplier_row
  import iterative_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [MUL_DIGIT-1:0] digit,
  output logic [WIDTH+3:0]     row
);

  localparam int N = WIDTH / MUL_DIGIT;

  logic [7:0] part_s [N];

  for (genvar k = 0; k < N; k++) begin : g_cell
    assign part_s[k] = base_mul4x4(a[MUL_DIGIT*k +: MUL_DIGIT], digit);
  end

  // Sum the cell partials, cell k weighted by 2^(4k)
  always_comb begin
    row = '0;
    for (int k = 0; k < N; k++) begin
      row = row + ((WIDTH+4)'(part_s[k]) << (MUL_DIGIT * k));
    end
  end

endmodule

// File: rtl/iterative_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one 4-bit digit of b per cycle,
// shifted row products accumulated into a 2*WIDTH register.
module iterative_multiplier
  import iterative_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int N     = WIDTH / MUL_DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if ((WIDTH % MUL_DIGIT) != 0 || WIDTH < 8) begin : g_bad_width
    $error("iterative_multiplier: WIDTH=%0d must be a multiple of 4 and at least 8", WIDTH);
  end

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [MUL_DIGIT-1:0] digit_s;
  logic [WIDTH+3:0]     row_s;
  logic [2*WIDTH-1:0]   sum_s;

  assign digit_s = b_q[{cnt_q, 2'b00} +: MUL_DIGIT];

  iterative_multiplier_row #(.WIDTH(WIDTH)) u_row (
    .a     (a_q),
    .digit (digit_s),
    .row   (row_s)
  );

  assign sum_s = acc_q + ((2*WIDTH)'(row_s) << {cnt_q, 2'b00});

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      MUL_IDLE, MUL_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_RUN;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        acc_d = sum_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          result_d = sum_s;
          state_d  = MUL_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = MUL_RUN;
        end
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
    busy_d = (state_d == MUL_RUN);
    done_d = (state_d == MUL_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Scoreboard bench for iterative_multiplier at WIDTH=32 and WIDTH=8; expected
// products come from plain wide multiplication.
module tb_iterative_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] result32;
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;

  iterative_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(result32)
  );

  iterative_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8)
  );

  typedef struct {
    logic [63:0] exp;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt32 = 0;
  int last_done32 = 0;
  int prev_done32 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor for the 32-bit instance
  always @(posedge clk) begin
    #1;
    if (done32 === 1'b1) begin
      done_cnt32++;
      prev_done32 = last_done32;
      last_done32 = cyc;
      if (q32.size() == 0) begin
        check("unexpected_done32", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("result32", result32, e.exp);
        check("latency32", 64'(cyc - e.acc), 64'd8);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(posedge clk) begin
    #1;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("result8", 64'(result8), e.exp);
        check("latency8", 64'(cyc - e.acc), 64'd2);
      end
    end
  end

  task automatic issue(input bit w8, input logic [31:0] x, input logic [31:0] y);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while ((w8 ? busy8 : busy32) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("issue_timeout", 64'd1, 64'd0);
    e.acc = cyc + 1;
    if (w8) begin
      start8 = 1'b1; a8 = x[7:0]; b8 = y[7:0];
      e.exp = {56'd0, x[7:0]} * {56'd0, y[7:0]};
      q8.push_back(e);
    end else begin
      start32 = 1'b1; a32 = x; b32 = y;
      e.exp = {32'd0, x} * {32'd0, y};
      q32.push_back(e);
    end
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic drain(input bit w8);
    int n;
    n = 0;
    while (((w8 ? q8.size() : q32.size()) != 0 || (w8 ? busy8 : busy32)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       pick32 = 32'd0;
      1:       pick32 = 32'hFFFF_FFFF;
      default: pick32 = $urandom;
    endcase
  endfunction

  initial begin
    int d0;
    rst_n = 1'b0;
    start32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    start8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_result32", result32, 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_result8", 64'(result8), 64'd0);
    rst_n = 1'b1;

    issue(1'b0, 32'd3, 32'd5);
    drain(1'b0);
    repeat (20) @(negedge clk);
    check("hold_result", result32, 64'd15);

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain(1'b0);
    check("max_result", result32, 64'hFFFF_FFFE_0000_0001);
    issue(1'b0, 32'h0001_0000, 32'h0001_0000);
    drain(1'b0);
    check("pow2_result", result32, 64'h0000_0001_0000_0000);

    d0 = done_cnt32;
    issue(1'b0, 32'hDEAD_BEEF, 32'd0);
    for (int i = 0; i < 5; i++) begin
      start32 = 1'b1; a32 = $urandom; b32 = $urandom;
      @(negedge clk);
    end
    start32 = 1'b0;
    drain(1'b0);
    repeat (3) @(negedge clk);
    check("ignored_done_count", 64'(done_cnt32 - d0), 64'd1);
    check("ignored_result", result32, 64'd0);

    issue(1'b0, 32'd11, 32'd13);
    issue(1'b0, 32'd7, 32'd9);
    drain(1'b0);
    check("b2b_spacing", 64'(last_done32 - prev_done32), 64'd9);
    check("b2b_result", result32, 64'd63);

    issue(1'b0, 32'd123456, 32'd654321);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_done", 64'(done32), 64'd0);
    check("midrst_result", result32, 64'd0);
    q32.delete();
    d0 = done_cnt32;
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt32 - d0), 64'd0);
    issue(1'b0, 32'd6, 32'd7);
    drain(1'b0);
    check("post_rst_result", result32, 64'd42);

    for (int i = 0; i < 1000; i++) begin
      issue(1'b0, pick32(), pick32());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(1'b0);

    issue(1'b1, 32'd255, 32'd255);
    drain(1'b1);
    check("max_result8", 64'(result8), 64'd65025);
    for (int i = 0; i < 1000; i++) begin
      issue(1'b1, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(1'b1);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
